wt_dcache_lru_upd_arb: RTL and testbench



---
 rtl/wt_dcache_lru_upd_arb.sv | 177 +++++++++++++++++
 tb/tb_wt_dcache_lru_upd_arb.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_dcache_lru_upd_arb.sv
// wt_dcache_lru_upd_arb: merges per-port dcache hit events and MSHR fill
// events into one registered LRU update per cycle; fills win, hits queue.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             drop all queued hit updates (drop counter kept)
//   hit_valid_i/idx/way per-port hit events (NUM_PORTS wide)
//   miss_valid_i/idx    MSHR fill event
//   lru_hit_o/idx/way   registered hit update to the LRU tracker
//   lru_miss_o/idx      registered fill update to the LRU tracker
//   fifo_full_o/empty_o hit FIFO occupancy flags (registered)
//   drop_cnt_o          saturating count of hit events that found no slot
module wt_dcache_lru_upd_arb #(
    parameter int unsigned NUM_PORTS  = 3,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IDX_WIDTH  = 8,
    parameter int unsigned WAY_WIDTH  = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    input  logic [NUM_PORTS-1:0]                hit_valid_i,
    input  logic [NUM_PORTS-1:0][IDX_WIDTH-1:0] hit_idx_i,
    input  logic [NUM_PORTS-1:0][WAY_WIDTH-1:0] hit_way_i,
    input  logic                                miss_valid_i,
    input  logic [IDX_WIDTH-1:0]                miss_idx_i,
    output logic                                lru_hit_o,
    output logic [IDX_WIDTH-1:0]                lru_hit_idx_o,
    output logic [WAY_WIDTH-1:0]                lru_hit_way_o,
    output logic                                lru_miss_o,
    output logic [IDX_WIDTH-1:0]                lru_miss_idx_o,
    output logic                                fifo_full_o,
    output logic                                fifo_empty_o,
    output logic [15:0]                         drop_cnt_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [IDX_WIDTH-1:0] idx_mem_q [FIFO_DEPTH];
    logic [IDX_WIDTH-1:0] idx_mem_d [FIFO_DEPTH];
    logic [WAY_WIDTH-1:0] way_mem_q [FIFO_DEPTH];
    logic [WAY_WIDTH-1:0] way_mem_d [FIFO_DEPTH];

    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                 lru_hit_q, lru_hit_d;
    logic [IDX_WIDTH-1:0] lru_hit_idx_q, lru_hit_idx_d;
    logic [WAY_WIDTH-1:0] lru_hit_way_q, lru_hit_way_d;
    logic                 lru_miss_q, lru_miss_d;
    logic [IDX_WIDTH-1:0] lru_miss_idx_q, lru_miss_idx_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;

    logic [NUM_PORTS-1:0] dup;
    logic [CNT_W-1:0]     free_slots;
    logic [CNT_W-1:0]     n_enq;
    logic [15:0]          n_drop;
    logic [16:0]          drop_sum;
    logic [PTR_W-1:0]     wr_addr;
    logic                 pop;

    always_comb begin
        idx_mem_d      = idx_mem_q;
        way_mem_d      = way_mem_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        lru_hit_d      = 1'b0;
        lru_hit_idx_d  = lru_hit_idx_q;
        lru_hit_way_d  = lru_hit_way_q;
        lru_miss_d     = 1'b0;
        lru_miss_idx_d = lru_miss_idx_q;
        drop_cnt_d     = drop_cnt_q;
        dup            = '0;
        n_enq          = '0;
        n_drop         = '0;
        drop_sum       = '0;
        wr_addr        = wr_ptr_q;

        // A port repeating a lower port's (idx, way) carries no new
        // information for the LRU, so it is folded away silently.
        for (int unsigned i = 1; i < NUM_PORTS; i++) begin
            for (int unsigned j = 0; j < i; j++) begin
                if (hit_valid_i[j] &&
                    hit_idx_i[j] == hit_idx_i[i] &&
                    hit_way_i[j] == hit_way_i[i]) begin
                    dup[i] = 1'b1;
                end
            end
        end

        // Slots freed by this cycle's pop are not counted as free.
        free_slots = CNT_W'(FIFO_DEPTH) - count_q;
        pop        = !miss_valid_i && (count_q != '0);

        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (hit_valid_i[i] && !dup[i]) begin
                if (n_enq < free_slots) begin
                    wr_addr            = wr_ptr_q + PTR_W'(n_enq);
                    idx_mem_d[wr_addr] = hit_idx_i[i];
                    way_mem_d[wr_addr] = hit_way_i[i];
                    n_enq              = n_enq + CNT_W'(1);
                end else begin
                    n_drop = n_drop + 16'd1;
                end
            end
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(n_enq);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + n_enq - CNT_W'(pop);

        if (miss_valid_i) begin
            lru_miss_d     = 1'b1;
            lru_miss_idx_d = miss_idx_i;
        end else if (pop) begin
            lru_hit_d     = 1'b1;
            lru_hit_idx_d = idx_mem_q[rd_ptr_q];
            lru_hit_way_d = way_mem_q[rd_ptr_q];
        end

        drop_sum   = {1'b0, drop_cnt_q} + {1'b0, n_drop};
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

        // Flush discards queued and incoming events; they are not drops.
        if (flush_i) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            lru_hit_d  = 1'b0;
            lru_miss_d = 1'b0;
            drop_cnt_d = drop_cnt_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            lru_hit_q      <= 1'b0;
            lru_hit_idx_q  <= '0;
            lru_hit_way_q  <= '0;
            lru_miss_q     <= 1'b0;
            lru_miss_idx_q <= '0;
            drop_cnt_q     <= '0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            lru_hit_q      <= lru_hit_d;
            lru_hit_idx_q  <= lru_hit_idx_d;
            lru_hit_way_q  <= lru_hit_way_d;
            lru_miss_q     <= lru_miss_d;
            lru_miss_idx_q <= lru_miss_idx_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    // Storage needs no reset: entries are only read below count_q.
    always_ff @(posedge clk_i) begin
        idx_mem_q <= idx_mem_d;
        way_mem_q <= way_mem_d;
    end

    assign lru_hit_o      = lru_hit_q;
    assign lru_hit_idx_o  = lru_hit_idx_q;
    assign lru_hit_way_o  = lru_hit_way_q;
    assign lru_miss_o     = lru_miss_q;
    assign lru_miss_idx_o = lru_miss_idx_q;
    assign fifo_full_o    = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty_o   = (count_q == '0);
    assign drop_cnt_o     = drop_cnt_q;

endmodule

// File: tb/tb_wt_dcache_lru_upd_arb.sv
// tb_wt_dcache_lru_upd_arb: directed bench with hit/miss scoreboard queues
// popped whenever the arbiter issues an LRU update.
module tb_wt_dcache_lru_upd_arb;

    logic            clk;
    logic            rst;
    logic            flush;
    logic [2:0]      hit_valid;
    logic [2:0][7:0] hit_idx;
    logic [2:0][1:0] hit_way;
    logic            miss_valid;
    logic [7:0]      miss_idx;
    logic            lru_hit_o;
    logic [7:0]      lru_hit_idx_o;
    logic [1:0]      lru_hit_way_o;
    logic            lru_miss_o;
    logic [7:0]      lru_miss_idx_o;
    logic            fifo_full_o;
    logic            fifo_empty_o;
    logic [15:0]     drop_cnt_o;

    typedef struct packed {
        logic [7:0] idx;
        logic [1:0] way;
    } upd_t;

    upd_t hit_q[$];
    upd_t miss_q[$];
    int   vectors;
    int   miscompares;

    wt_dcache_lru_upd_arb #(
        .NUM_PORTS  (3),
        .FIFO_DEPTH (4),
        .IDX_WIDTH  (8),
        .WAY_WIDTH  (2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .hit_valid_i    (hit_valid),
        .hit_idx_i      (hit_idx),
        .hit_way_i      (hit_way),
        .miss_valid_i   (miss_valid),
        .miss_idx_i     (miss_idx),
        .lru_hit_o      (lru_hit_o),
        .lru_hit_idx_o  (lru_hit_idx_o),
        .lru_hit_way_o  (lru_hit_way_o),
        .lru_miss_o     (lru_miss_o),
        .lru_miss_idx_o (lru_miss_idx_o),
        .fifo_full_o    (fifo_full_o),
        .fifo_empty_o   (fifo_empty_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] req);
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, req);
        end
    endtask

    task automatic clear_in();
        flush      = 1'b0;
        hit_valid  = '0;
        hit_idx    = '0;
        hit_way    = '0;
        miss_valid = 1'b0;
        miss_idx   = '0;
    endtask

    task automatic set_hit(input int p, input logic [7:0] i,
                           input logic [1:0] w);
        hit_valid[p] = 1'b1;
        hit_idx[p]   = i;
        hit_way[p]   = w;
    endtask

    task automatic set_miss(input logic [7:0] i);
        miss_valid = 1'b1;
        miss_idx   = i;
    endtask

    task automatic exp_hit(input logic [7:0] i, input logic [1:0] w);
        upd_t e;
        e.idx = i;
        e.way = w;
        hit_q.push_back(e);
    endtask

    task automatic exp_miss(input logic [7:0] i);
        upd_t e;
        e.idx = i;
        e.way = '0;
        miss_q.push_back(e);
    endtask

    // One clock; outputs sampled on the falling edge and scoreboarded.
    task automatic cyc();
        upd_t e;
        @(posedge clk);
        @(negedge clk);
        chk("hit_miss_excl", 32'(lru_hit_o & lru_miss_o), 32'd0);
        if (lru_miss_o === 1'b1) begin
            vectors++;
            assert (miss_q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexp_miss: observed miss idx %0h, required none",
                       lru_miss_idx_o);
            end
            if (miss_q.size() != 0) begin
                e = miss_q.pop_front();
                chk("miss_idx", 32'(lru_miss_idx_o), 32'(e.idx));
            end
        end
        if (lru_hit_o === 1'b1) begin
            vectors++;
            assert (hit_q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexp_hit: observed hit %0h/%0h, required none",
                       lru_hit_idx_o, lru_hit_way_o);
            end
            if (hit_q.size() != 0) begin
                e = hit_q.pop_front();
                chk("hit_idx", 32'(lru_hit_idx_o), 32'(e.idx));
                chk("hit_way", 32'(lru_hit_way_o), 32'(e.way));
            end
        end
    endtask

    task automatic chk_drained();
        chk("pending_hits", 32'(hit_q.size()), 32'd0);
        chk("pending_miss", 32'(miss_q.size()), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        clear_in();

        // Reset
        cyc();
        cyc();
        chk("rst_hit", 32'(lru_hit_o), 32'd0);
        chk("rst_miss", 32'(lru_miss_o), 32'd0);
        chk("rst_empty", 32'(fifo_empty_o), 32'd1);
        chk("rst_full", 32'(fifo_full_o), 32'd0);
        chk("rst_drop", 32'(drop_cnt_o), 32'd0);
        rst = 1'b0;

        // Single hit: two-cycle latency through the FIFO
        set_hit(0, 8'd5, 2'd2);
        exp_hit(8'd5, 2'd2);
        cyc();
        clear_in();
        chk("t1_lat1_hit", 32'(lru_hit_o), 32'd0);
        chk("t1_lat1_empty", 32'(fifo_empty_o), 32'd0);
        cyc();
        chk("t1_lat2_hit", 32'(lru_hit_o), 32'd1);
        cyc();
        chk("t1_after_hit", 32'(lru_hit_o), 32'd0);
        chk("t1_after_empty", 32'(fifo_empty_o), 32'd1);
        chk_drained();

        // Miss wins over a concurrent hit
        set_miss(8'd7);
        set_hit(1, 8'd3, 2'd1);
        exp_miss(8'd7);
        exp_hit(8'd3, 2'd1);
        cyc();
        clear_in();
        chk("t2_miss", 32'(lru_miss_o), 32'd1);
        cyc();
        chk("t2_hit", 32'(lru_hit_o), 32'd1);
        cyc();
        chk_drained();

        // Miss stream starves hits; FIFO fills and drops accumulate
        for (int k = 0; k < 4; k++) begin
            set_miss(8'(10 + k));
            exp_miss(8'(10 + k));
            for (int p = 0; p < 3; p++) begin
                set_hit(p, 8'(16 * (k + 1) + p), 2'(p));
                if (k == 0 || (k == 1 && p == 0))
                    exp_hit(8'(16 * (k + 1) + p), 2'(p));
            end
            cyc();
            if (k == 0)
                chk("t3_drop_c1", 32'(drop_cnt_o), 32'd0);
        end
        clear_in();
        chk("t3_full", 32'(fifo_full_o), 32'd1);
        chk("t3_drop", 32'(drop_cnt_o), 32'd8);
        repeat (5) cyc();
        chk("t3_empty", 32'(fifo_empty_o), 32'd1);
        chk_drained();

        // Same-cycle duplicates merge
        set_hit(0, 8'd9, 2'd0);
        set_hit(1, 8'd9, 2'd3);
        set_hit(2, 8'd9, 2'd0);
        exp_hit(8'd9, 2'd0);
        exp_hit(8'd9, 2'd3);
        cyc();
        clear_in();
        chk("t4_empty", 32'(fifo_empty_o), 32'd0);
        repeat (3) cyc();
        chk("t4_drop", 32'(drop_cnt_o), 32'd8);
        chk("t4_empty_end", 32'(fifo_empty_o), 32'd1);
        chk_drained();

        // Flush with three queued entries plus concurrent miss and hit
        set_miss(8'd1);
        exp_miss(8'd1);
        for (int p = 0; p < 3; p++)
            set_hit(p, 8'(32 + p), 2'(p));
        cyc();
        clear_in();
        flush = 1'b1;
        set_miss(8'd2);
        set_hit(0, 8'd4, 2'd1);
        cyc();
        clear_in();
        chk("t5_hit", 32'(lru_hit_o), 32'd0);
        chk("t5_miss", 32'(lru_miss_o), 32'd0);
        chk("t5_empty", 32'(fifo_empty_o), 32'd1);
        chk("t5_drop", 32'(drop_cnt_o), 32'd8);
        repeat (3) cyc();
        chk_drained();

        // Drop counter saturation on a full FIFO
        set_miss(8'h20);
        exp_miss(8'h20);
        for (int p = 0; p < 3; p++) begin
            set_hit(p, 8'(8'h60 + p), 2'(p));
            exp_hit(8'(8'h60 + p), 2'(p));
        end
        cyc();
        exp_miss(8'h20);
        for (int p = 0; p < 3; p++)
            set_hit(p, 8'(8'h70 + p), 2'(p));
        exp_hit(8'h70, 2'd0);
        cyc();
        chk("t6_drop10", 32'(drop_cnt_o), 32'd10);
        for (int p = 0; p < 3; p++)
            set_hit(p, 8'(p), 2'(p));
        for (int n = 0; n < 21841; n++) begin
            exp_miss(8'h20);
            cyc();
        end
        chk("t6_fffd", 32'(drop_cnt_o), 32'hFFFD);
        hit_valid = 3'b001;
        exp_miss(8'h20);
        cyc();
        chk("t6_fffe", 32'(drop_cnt_o), 32'hFFFE);
        exp_miss(8'h20);
        cyc();
        chk("t6_ffff", 32'(drop_cnt_o), 32'hFFFF);
        exp_miss(8'h20);
        cyc();
        chk("t6_sat1", 32'(drop_cnt_o), 32'hFFFF);
        hit_valid = 3'b111;
        exp_miss(8'h20);
        cyc();
        chk("t6_sat3", 32'(drop_cnt_o), 32'hFFFF);
        chk("t6_full", 32'(fifo_full_o), 32'd1);
        clear_in();
        repeat (6) cyc();
        chk("t6_empty", 32'(fifo_empty_o), 32'd1);
        chk_drained();

        // Mid-operation reset discards buffered entries
        set_miss(8'h44);
        exp_miss(8'h44);
        set_hit(0, 8'h50, 2'd1);
        set_hit(1, 8'h51, 2'd2);
        cyc();
        clear_in();
        rst = 1'b1;
        cyc();
        chk("t7_hit", 32'(lru_hit_o), 32'd0);
        chk("t7_miss", 32'(lru_miss_o), 32'd0);
        chk("t7_empty", 32'(fifo_empty_o), 32'd1);
        chk("t7_full", 32'(fifo_full_o), 32'd0);
        chk("t7_drop", 32'(drop_cnt_o), 32'd0);
        rst = 1'b0;
        repeat (3) cyc();
        chk_drained();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
